// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: NPC select encodings
// (also used by the controller), reset PC and fetch FSM states.
package mips_pkg;

   localparam logic [1:0]  NPC_PC4  = 2'b00;
   localparam logic [1:0]  NPC_J    = 2'b01;
   localparam logic [1:0]  NPC_JR   = 2'b10;
   localparam logic [1:0]  NPC_BEQ  = 2'b11;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_unit_if.sv
// Instruction memory fetch bus.
// Handshake: imem_req is raised by the fetch unit and held, together with a
// stable imem_addr, until the memory answers with imem_ack=1 for one cycle;
// imem_rdata is only meaningful in that ack cycle. Ack without req is ignored.
interface ifu_fetch_unit_if #(
   parameter int ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;

   modport master (output imem_req, output imem_addr,
                   input  imem_ack, input  imem_rdata);
   modport slave  (input  imem_req, input  imem_addr,
                   output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifu_npc.sv
// Combinational next-PC calculator. All arithmetic wraps modulo 2^32.
module ifu_npc
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] pc_4,
   input  logic [25:0] instr_index,
   input  logic [15:0] imm16,
   input  logic [31:2] jr_target,
   input  logic [1:0]  npc_sel,
   output logic [31:0] npc
);

   logic [31:0] br_offset;

   // Sign-extended, word-scaled branch displacement.
   always_comb begin
      br_offset = {{14{imm16[15]}}, imm16, 2'b00};
   end

   // Select the next PC source; jr target is forced word aligned.
   always_comb begin
      npc = pc + 32'd4;
      case (npc_sel)
         NPC_PC4: npc = pc + 32'd4;
         NPC_J:   npc = {pc_4[31:28], instr_index, 2'b00};
         NPC_JR:  npc = {jr_target, 2'b00};
         NPC_BEQ: npc = pc_4 + br_offset;
         default: npc = pc + 32'd4;
      endcase
   end

endmodule

// File: rtl/ifu_fetch_unit.sv
// Instruction fetch stage: PC / IR / PC+4 registers, a two-state fetch FSM
// driving the instruction memory handshake, and IR field decode.
module ifu_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
   parameter int          ADDR_W   = 32
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                pc_wr,
   input  logic                ir_wr,
   input  logic [1:0]          npc_sel,
   input  logic [31:0]         gpr_ra,
   ifu_fetch_unit_if.master    imem,
   output logic                fetch_done,
   output logic                fetch_busy,
   output logic [31:0]         instr,
   output logic [5:0]          opcode,
   output logic [5:0]          funct,
   output logic [4:0]          rs,
   output logic [4:0]          rt,
   output logic [4:0]          rd,
   output logic [15:0]         imm16,
   output logic [ADDR_W-1:0]   pc,
   output logic [ADDR_W-1:0]   pc_4,
   output logic                misalign,
   output ifu_state_e          state
);

   ifu_state_e        state_nxt;
   logic [ADDR_W-1:0] fetch_pc;
   logic [31:0]       ir;
   logic [31:0]       npc;
   logic              start_fetch;
   logic              take_ack;

   ifu_npc u_npc (
      .pc          (pc),
      .pc_4        (pc_4),
      .instr_index (ir[25:0]),
      .imm16       (ir[15:0]),
      .jr_target   (gpr_ra[31:2]),
      .npc_sel     (npc_sel),
      .npc         (npc)
   );

   // Next-state logic: ir_wr only starts a fetch from IDLE, ack only ends one in WAIT.
   always_comb begin
      state_nxt   = state;
      start_fetch = 1'b0;
      take_ack    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ir_wr) begin
               start_fetch = 1'b1;
               state_nxt   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem.imem_ack) begin
               take_ack  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, PC, IR and status registers; reset abandons any outstanding fetch.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         pc         <= RESET_PC;
         pc_4       <= RESET_PC + 32'd4;
         fetch_pc   <= RESET_PC;
         ir         <= 32'h0;
         fetch_done <= 1'b0;
         misalign   <= 1'b0;
      end else begin
         state      <= state_nxt;
         fetch_done <= take_ack;
         if (start_fetch) begin
            // pc here is the pre-update value even when pc_wr is also high.
            fetch_pc <= pc;
            pc_4     <= pc + 32'd4;
         end
         if (take_ack) begin
            ir <= imem.imem_rdata;
         end
         if (pc_wr) begin
            pc <= npc;
            if (npc_sel == NPC_JR && gpr_ra[1:0] != 2'b00) begin
               misalign <= 1'b1;
            end
         end
      end
   end

   // Bus outputs and IR field decode.
   always_comb begin
      imem.imem_req  = (state == ST_WAIT);
      imem.imem_addr = fetch_pc;
      fetch_busy     = (state == ST_WAIT);
      instr          = ir;
      opcode         = ir[31:26];
      rs             = ir[25:21];
      rt             = ir[20:16];
      rd             = ir[15:11];
      imm16          = ir[15:0];
      funct          = ir[5:0];
   end

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Self-checking bench for ifu_fetch_unit: a memory responder driven by
// tasks, a scoreboard of expected instruction words, and fixed-value checks
// of PC arithmetic, handshake timing and reset behaviour.
module tb_ifu_fetch_unit;
   import mips_pkg::*;

   logic        clk;
   logic        rst;
   logic        pc_wr;
   logic        ir_wr;
   logic [1:0]  npc_sel;
   logic [31:0] gpr_ra;
   logic        fetch_done;
   logic        fetch_busy;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm16;
   logic [31:0] pc;
   logic [31:0] pc_4;
   logic        misalign;
   ifu_state_e  dut_state;

   ifu_fetch_unit_if imem_bus ();

   ifu_fetch_unit dut (
      .clk        (clk),
      .rst        (rst),
      .pc_wr      (pc_wr),
      .ir_wr      (ir_wr),
      .npc_sel    (npc_sel),
      .gpr_ra     (gpr_ra),
      .imem       (imem_bus.master),
      .fetch_done (fetch_done),
      .fetch_busy (fetch_busy),
      .instr      (instr),
      .opcode     (opcode),
      .funct      (funct),
      .rs         (rs),
      .rt         (rt),
      .rd         (rd),
      .imm16      (imm16),
      .pc         (pc),
      .pc_4       (pc_4),
      .misalign   (misalign),
      .state      (dut_state)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   int          n_checks = 0;
   int          n_errors = 0;
   int          done_cnt = 0;
   int          n_fetch  = 0;
   logic [31:0] m_pc;
   logic [31:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every fetch_done pulse must deliver the oldest expected word.
   always @(negedge clk) begin
      if (fetch_done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check_val("unexpected_done", 32'd1, 32'd0);
         end else begin
            check_val("sb_instr", instr, exp_q.pop_front());
         end
      end
   end

   // One fetch: ir_wr (optionally with pc_wr/PC+4), waits stall cycles, then ack.
   // poke raises ir_wr again in the first WAIT cycle (needs waits >= 1).
   task automatic do_fetch(input logic [31:0] data, input int waits,
                           input logic with_pcw, input logic poke);
      logic [31:0] exp_addr;
      exp_addr = m_pc;
      exp_q.push_back(data);
      n_fetch++;
      ir_wr   = 1'b1;
      pc_wr   = with_pcw;
      npc_sel = NPC_PC4;
      @(negedge clk);
      ir_wr = 1'b0;
      pc_wr = 1'b0;
      if (with_pcw) m_pc = m_pc + 32'd4;
      for (int i = 0; i < waits; i++) begin
         check_val("wait_req", {31'b0, imem_bus.imem_req}, 32'd1);
         check_val("wait_addr", imem_bus.imem_addr, exp_addr);
         if (poke && i == 0) ir_wr = 1'b1;
         @(negedge clk);
         ir_wr = 1'b0;
      end
      check_val("ack_req", {31'b0, imem_bus.imem_req}, 32'd1);
      check_val("ack_addr", imem_bus.imem_addr, exp_addr);
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = data;
      @(negedge clk);
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = $urandom;
      check_val("done_pulse", {31'b0, fetch_done}, 32'd1);
      check_val("busy_after", {31'b0, fetch_busy}, 32'd0);
      check_val("pc_4_after", pc_4, exp_addr + 32'd4);
      check_val("pc_after", pc, m_pc);
   endtask

   // Single PC update through the NPC mux.
   task automatic do_pcw(input logic [1:0] sel, input logic [31:0] ra);
      pc_wr   = 1'b1;
      npc_sel = sel;
      gpr_ra  = ra;
      @(negedge clk);
      pc_wr   = 1'b0;
      npc_sel = NPC_PC4;
   endtask

   // After a fetch: fetch_done must drop and the pulse count must match.
   task automatic check_done_count();
      @(negedge clk);
      check_val("done_drop", {31'b0, fetch_done}, 32'd0);
      check_val("done_cnt", done_cnt, n_fetch);
   endtask

   initial begin
      rst = 1'b0; pc_wr = 1'b0; ir_wr = 1'b0; npc_sel = NPC_PC4; gpr_ra = 32'h0;
      imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;

      // Reset held for two cycles.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_pc", pc, 32'h0000_3000);
      check_val("rst_pc_4", pc_4, 32'h0000_3004);
      check_val("rst_instr", instr, 32'h0);
      check_val("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
      check_val("rst_done", {31'b0, fetch_done}, 32'd0);
      check_val("rst_misalign", {31'b0, misalign}, 32'd0);
      check_val("rst_state", 32'(dut_state), 32'(ST_IDLE));
      rst  = 1'b1;
      m_pc = 32'h0000_3000;
      @(negedge clk);

      // Fetch with simultaneous PC+4 update, three stall cycles.
      do_fetch(32'h3C01_1234, 3, 1'b1, 1'b0);
      check_val("lui_pc", pc, 32'h0000_3004);
      check_val("lui_pc_4", pc_4, 32'h0000_3004);
      check_val("lui_opcode", {26'b0, opcode}, 32'h0F);
      check_val("lui_rt", {27'b0, rt}, 32'd1);
      check_val("lui_imm16", {16'b0, imm16}, 32'h1234);
      check_done_count();

      // beq with offset -1: pc_4=0x3008 -> target 0x3004 (zero-wait fetch).
      do_fetch(32'h1000_FFFF, 0, 1'b1, 1'b0);
      check_val("beq_pc_4", pc_4, 32'h0000_3008);
      do_pcw(NPC_BEQ, 32'h0);
      check_val("beq_pc", pc, 32'h0000_3004);
      m_pc = 32'h0000_3004;

      // j 0x0C10 -> 0x3040.
      do_fetch(32'h0800_0C10, 1, 1'b1, 1'b0);
      check_val("j_funct", {26'b0, funct}, 32'h10);
      do_pcw(NPC_J, 32'h0);
      check_val("j_pc", pc, 32'h0000_3040);

      // jr to misaligned target: aligned PC, sticky misalign.
      do_pcw(NPC_JR, 32'h0000_3102);
      check_val("jr_pc", pc, 32'h0000_3100);
      check_val("jr_misalign", {31'b0, misalign}, 32'd1);
      do_pcw(NPC_PC4, 32'h0);
      check_val("seq_pc", pc, 32'h0000_3104);
      check_val("misalign_sticky", {31'b0, misalign}, 32'd1);
      m_pc = 32'h0000_3104;

      // ir_wr during WAIT is ignored.
      do_fetch(32'h0000_0020, 2, 1'b0, 1'b1);
      check_done_count();

      // Random word / stall / pc_wr mix.
      for (int k = 0; k < 6; k++) begin
         do_fetch($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
         check_val("rnd_fields", {opcode, rs, rt, rd, 5'(instr[10:6]), funct}, instr);
      end
      check_done_count();

      // Reset in the middle of a fetch, then a stale ack.
      ir_wr = 1'b1;
      @(negedge clk);
      ir_wr = 1'b0;
      check_val("mid_busy", {31'b0, fetch_busy}, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_bus.imem_ack = 1'b0;
      check_val("abort_instr", instr, 32'h0);
      check_val("abort_state", 32'(dut_state), 32'(ST_IDLE));
      check_val("abort_req", {31'b0, imem_bus.imem_req}, 32'd0);
      check_val("abort_misalign", {31'b0, misalign}, 32'd0);
      check_val("abort_pc", pc, 32'h0000_3000);
      check_done_count();

      // PC wrap-around at the top of the address space.
      do_pcw(NPC_JR, 32'hFFFF_FFFC);
      check_val("top_pc", pc, 32'hFFFF_FFFC);
      check_val("top_misalign", {31'b0, misalign}, 32'd0);
      do_pcw(NPC_PC4, 32'h0);
      check_val("wrap_pc", pc, 32'h0000_0000);

      check_val("sb_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
